// File: rtl/pc_scheduler.sv
// pc_scheduler: two-FIFO thread scheduler that feeds basic_block and steps through characters.
module pc_fifo #(
    parameter int W = 8,
    parameter int L = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_flush,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_head,
    output logic         o_empty,
    output logic         o_full
);
    logic [W-1:0] r_mem [2**L];
    logic [L-1:0] r_wr;
    logic [L-1:0] r_rd;
    logic [L:0]   r_cnt;
    logic         w_push;
    logic         w_pop;
    assign o_head  = r_mem[r_rd];
    assign o_empty = r_cnt == '0;
    assign o_full  = r_cnt[L];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= i_data;
                r_wr        <= r_wr + L'(1);
            end
            if (w_pop)
                r_rd <= r_rd + L'(1);
            r_cnt <= r_cnt + (L+1)'(w_push) - (L+1)'(w_pop);
        end
    end
endmodule

module pc_scheduler #(
    parameter int PC_WIDTH         = 8,
    parameter int FIFO_DEPTH_LOG   = 4,
    parameter int CHAR_INDEX_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start_valid,
    input  logic [PC_WIDTH-1:0]         start_pc,
    output logic                        start_ready,
    input  logic [CHAR_INDEX_WIDTH-1:0] string_length,
    input  logic                        in_pc_valid,
    input  logic [PC_WIDTH-1:0]         in_pc,
    input  logic                        in_pc_is_directed_to_current,
    output logic                        in_pc_ready,
    output logic                        out_pc_valid,
    output logic [PC_WIDTH-1:0]         out_pc,
    input  logic                        out_pc_ready,
    input  logic                        bb_busy,
    input  logic                        accepts,
    output logic [CHAR_INDEX_WIDTH-1:0] char_index,
    output logic                        advance,
    output logic                        done,
    output logic                        match,
    input  logic                        done_ack
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_ADV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;
    logic [1:0]                  r_state;
    logic [1:0]                  w_state_nxt;
    logic                        r_cur_sel;
    logic                        r_match;
    logic                        r_pop_prev;
    logic [CHAR_INDEX_WIDTH-1:0] r_len;
    logic [CHAR_INDEX_WIDTH-1:0] r_idx;
    logic [CHAR_INDEX_WIDTH:0]   w_idx_inc;
    logic [PC_WIDTH-1:0]         w_head_a;
    logic [PC_WIDTH-1:0]         w_head_b;
    logic [PC_WIDTH-1:0]         w_push_data;
    logic w_empty_a, w_empty_b, w_full_a, w_full_b;
    logic w_run, w_done_st, w_cur_empty, w_nxt_empty, w_tgt_b, w_tgt_full;
    logic w_start, w_pop, w_push, w_push_a, w_push_b, w_quiet, w_last;
    assign w_run       = r_state == S_RUN;
    assign w_done_st   = r_state == S_DONE;
    assign w_cur_empty = r_cur_sel ? w_empty_b : w_empty_a;
    assign w_nxt_empty = r_cur_sel ? w_empty_a : w_empty_b;
    // B is the target when it is current and the PC stays, or it is next and the PC moves on
    assign w_tgt_b     = r_cur_sel == in_pc_is_directed_to_current;
    assign w_tgt_full  = w_tgt_b ? w_full_b : w_full_a;
    assign start_ready  = !reset && r_state == S_IDLE;
    assign out_pc_valid = !reset && w_run && !w_cur_empty;
    assign out_pc       = reset ? '0 : (r_cur_sel ? w_head_b : w_head_a);
    assign in_pc_ready  = !reset && (w_done_st || (w_run && !w_tgt_full));
    assign char_index   = reset ? '0 : r_idx;
    assign advance      = !reset && r_state == S_ADV;
    assign done         = !reset && w_done_st;
    assign match        = !reset && w_done_st && r_match;
    assign w_start     = start_ready && start_valid;
    assign w_pop       = out_pc_valid && out_pc_ready;
    assign w_push      = w_run && in_pc_valid && in_pc_ready;
    assign w_push_a    = (w_start && !r_cur_sel) || (w_push && !w_tgt_b);
    assign w_push_b    = (w_start && r_cur_sel) || (w_push && w_tgt_b);
    assign w_push_data = w_start ? start_pc : in_pc;
    assign w_quiet     = w_cur_empty && !bb_busy && !in_pc_valid && !w_pop && !r_pop_prev;
    assign w_idx_inc   = {1'b0, r_idx} + (CHAR_INDEX_WIDTH+1)'(1);
    assign w_last      = w_idx_inc >= {1'b0, r_len};
    assign w_state_nxt = (r_state == S_IDLE) ? (start_valid ? S_RUN : S_IDLE) :
                         (r_state == S_RUN)  ? (accepts ? S_DONE :
                                                !w_quiet ? S_RUN :
                                                (w_nxt_empty || w_last) ? S_DONE : S_ADV) :
                         (r_state == S_ADV)  ? S_RUN :
                         (done_ack ? S_IDLE : S_DONE);
    pc_fifo #(.W(PC_WIDTH), .L(FIFO_DEPTH_LOG)) u_fifo_a (
        .clk(clk), .reset(reset), .i_flush(w_done_st), .i_push(w_push_a), .i_data(w_push_data),
        .i_pop(w_pop && !r_cur_sel), .o_head(w_head_a), .o_empty(w_empty_a), .o_full(w_full_a)
    );
    pc_fifo #(.W(PC_WIDTH), .L(FIFO_DEPTH_LOG)) u_fifo_b (
        .clk(clk), .reset(reset), .i_flush(w_done_st), .i_push(w_push_b), .i_data(w_push_data),
        .i_pop(w_pop && r_cur_sel), .o_head(w_head_b), .o_empty(w_empty_b), .o_full(w_full_b)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cur_sel  <= 1'b0;
            r_match    <= 1'b0;
            r_pop_prev <= 1'b0;
            r_len      <= '0;
            r_idx      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pop_prev <= w_pop;
            if (w_start) begin
                r_len   <= string_length;
                r_idx   <= '0;
                r_match <= 1'b0;
            end
            if (w_run && accepts)
                r_match <= 1'b1;
            if (r_state == S_ADV) begin
                r_cur_sel <= ~r_cur_sel;
                r_idx     <= w_idx_inc[CHAR_INDEX_WIDTH-1:0];
            end
        end
    end
endmodule

// File: tb/tb_pc_scheduler.sv
// tb_pc_scheduler: self-checking bench for pc_scheduler with a small basic_block model.
module tb_pc_scheduler;
    localparam int PW = 8;
    localparam int CW = 16;
    logic          clk = 0;
    logic          reset = 1;
    logic          start_valid = 0;
    logic [PW-1:0] start_pc = '0;
    logic [CW-1:0] string_length = '0;
    logic          in_pc_valid = 0;
    logic [PW-1:0] in_pc = '0;
    logic          in_dir = 0;
    logic          out_pc_ready = 0;
    logic          bb_busy = 0;
    logic          accepts = 0;
    logic          done_ack = 0;
    logic          start_ready, in_pc_ready, out_pc_valid, advance, done, match;
    logic [PW-1:0] out_pc;
    logic [CW-1:0] char_index;
    int            n_pass = 0;
    int            n_total = 0;
    int            adv_n, first_c, acc, disp;
    bit            run_ok;
    logic [PW-1:0] nxt;
    logic [PW-1:0] e;
    logic [PW-1:0] sb[$];
    logic [PW:0]   pend[$];

    always #5 clk = ~clk;

    pc_scheduler #(.PC_WIDTH(PW), .FIFO_DEPTH_LOG(4), .CHAR_INDEX_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .start_valid(start_valid), .start_pc(start_pc),
        .start_ready(start_ready), .string_length(string_length), .in_pc_valid(in_pc_valid),
        .in_pc(in_pc), .in_pc_is_directed_to_current(in_dir), .in_pc_ready(in_pc_ready),
        .out_pc_valid(out_pc_valid), .out_pc(out_pc), .out_pc_ready(out_pc_ready),
        .bb_busy(bb_busy), .accepts(accepts), .char_index(char_index), .advance(advance),
        .done(done), .match(match), .done_ack(done_ack)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [PW-1:0] pc, input logic [CW-1:0] len);
        start_valid = 1;
        start_pc = pc;
        string_length = len;
        sb.push_back(pc);
        cyc();
        start_valid = 0;
    endtask

    // mode 0: BB returns nothing; 1: 0x05 -> 0x06 to current; 2: any -> 0x11 to next
    task automatic run_bb(input int mode, input int max_cyc, output int adv, output int first, output bit ok);
        logic [PW:0] p;
        logic [PW-1:0] x;
        adv = 0;
        first = -1;
        ok = 0;
        for (int c = 0; c < max_cyc && !ok; c++) begin
            @(negedge clk);
            if (done) ok = 1;
            else begin
                if (advance) adv++;
                if (in_pc_valid && in_pc_ready) begin
                    p = pend.pop_front();
                    sb.push_back(p[PW-1:0]);
                end
                if (out_pc_valid && out_pc_ready) begin
                    if (first < 0) first = c;
                    n_total++;
                    if (sb.size() == 0) $display("FAIL dispatch: got %h, none expected", out_pc);
                    else begin
                        x = sb.pop_front();
                        if (out_pc !== x) $display("FAIL dispatch: got %h exp %h", out_pc, x);
                        else n_pass++;
                    end
                    if (mode == 1 && out_pc == 8'h05) pend.push_back({1'b1, 8'h06});
                    if (mode == 2) pend.push_back({1'b0, 8'h11});
                end
                cyc();
                in_pc_valid = pend.size() > 0;
                bb_busy = pend.size() > 0;
                if (pend.size() > 0) {in_dir, in_pc} = pend[0];
            end
        end
        n_total++;
        if (!ok) $display("FAIL run_timeout: done=%b exp 1 within %0d cycles", done, max_cyc);
        else n_pass++;
    endtask

    task automatic finish_run();
        in_pc_valid = 0;
        bb_busy = 0;
        pend.delete();
        done_ack = 1;
        cyc();
        done_ack = 0;
        @(negedge clk);
        n_total++;
        if ({done, start_ready} !== 2'b01) $display("FAIL done_ack: {done,start_ready}=%b exp 01", {done, start_ready});
        else n_pass++;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_total++;
        if ({start_ready, in_pc_ready, out_pc_valid, out_pc, advance, done, match, char_index} !== '0)
            $display("FAIL reset_outputs: got %h exp 0", {start_ready, in_pc_ready, out_pc_valid, out_pc, advance, done, match, char_index});
        else n_pass++;
        cyc();
        reset = 0;
        @(negedge clk);
        n_total++;
        if ({start_ready, in_pc_ready, out_pc_valid, advance, done, match, char_index} !== {1'b1, 21'd0})
            $display("FAIL post_reset: got %h exp %h", {start_ready, in_pc_ready, out_pc_valid, advance, done, match, char_index}, {1'b1, 21'd0});
        else n_pass++;
    endtask

    task automatic test_single_char();
        sb.delete();
        out_pc_ready = 1;
        do_start(8'h05, 3);
        run_bb(1, 60, adv_n, first_c, run_ok);
        n_total++;
        if (first_c !== 0) $display("FAIL t1_latency: first dispatch cycle %0d exp 0", first_c); else n_pass++;
        n_total++;
        if ({adv_n, match, char_index} !== {32'd0, 1'b0, 16'd0})
            $display("FAIL t1_verdict: adv=%0d match=%b idx=%0d exp 0 0 0", adv_n, match, char_index);
        else n_pass++;
        n_total++;
        if (sb.size() !== 0) $display("FAIL t1_left: %0d undispatched exp 0", sb.size()); else n_pass++;
        finish_run();
    endtask

    task automatic test_advance(input logic [CW-1:0] len, input int exp_adv);
        sb.delete();
        out_pc_ready = 1;
        do_start(8'h10, len);
        run_bb(2, 200, adv_n, first_c, run_ok);
        n_total++;
        if (adv_n !== exp_adv) $display("FAIL adv_count: got %0d exp %0d", adv_n, exp_adv); else n_pass++;
        n_total++;
        if (char_index !== CW'(exp_adv)) $display("FAIL adv_index: got %0d exp %0d", char_index, exp_adv); else n_pass++;
        n_total++;
        if ({done, match} !== 2'b10) $display("FAIL adv_verdict: {done,match}=%b exp 10", {done, match}); else n_pass++;
        n_total++;
        if (sb.size() !== 1) $display("FAIL adv_left: %0d queued exp 1", sb.size()); else n_pass++;
        finish_run();
    endtask

    task automatic test_accept();
        sb.delete();
        out_pc_ready = 0;
        do_start(8'h20, 8);
        for (int k = 1; k <= 4; k++) begin
            in_pc_valid = 1;
            in_pc = 8'h20 + PW'(k);
            in_dir = 1;
            bb_busy = 1;
            cyc();
        end
        in_pc = 8'h25;
        accepts = 1;
        cyc();
        accepts = 0;
        in_pc = 8'h26;
        @(negedge clk);
        n_total++;
        if ({done, match, out_pc_valid, in_pc_ready} !== 4'b1101)
            $display("FAIL accept: {done,match,out_valid,in_ready}=%b exp 1101", {done, match, out_pc_valid, in_pc_ready});
        else n_pass++;
        cyc();
        finish_run();
        sb.delete();
        out_pc_ready = 1;
        do_start(8'h30, 8);
        run_bb(0, 60, adv_n, first_c, run_ok);
        n_total++;
        if ({sb.size() == 0, adv_n == 0, match} !== 3'b110)
            $display("FAIL accept_flush: left=%0d adv=%0d match=%b exp 0 0 0", sb.size(), adv_n, match);
        else n_pass++;
        finish_run();
    endtask

    task automatic test_full_fifo();
        sb.delete();
        out_pc_ready = 0;
        do_start(8'h40, 8);
        nxt = 8'h41;
        acc = 0;
        for (int k = 0; k < 17; k++) begin
            in_pc_valid = 1;
            in_pc = nxt;
            in_dir = 1;
            bb_busy = 1;
            @(negedge clk);
            if (in_pc_ready) begin
                sb.push_back(nxt);
                nxt++;
                acc++;
            end
            cyc();
        end
        @(negedge clk);
        n_total++;
        if ({acc == 15, in_pc_ready} !== 2'b10) $display("FAIL full: accepted=%0d in_ready=%b exp 15 0", acc, in_pc_ready); else n_pass++;
        out_pc_ready = 1;
        e = sb.pop_front();
        n_total++;
        if ({out_pc_valid, out_pc} !== {1'b1, e}) $display("FAIL full_pop: out=%h exp %h", out_pc, e); else n_pass++;
        cyc();
        out_pc_ready = 0;
        @(negedge clk);
        n_total++;
        if (in_pc_ready !== 1'b1) $display("FAIL full_rise: in_ready=%b exp 1", in_pc_ready); else n_pass++;
        sb.push_back(nxt);
        nxt++;
        cyc();
        out_pc_ready = 1;
        disp = 1;
        for (int c = 0; c < 300 && disp < 40; c++) begin
            in_pc_valid = nxt < 8'h68;
            in_pc = nxt;
            bb_busy = in_pc_valid;
            @(negedge clk);
            if (out_pc_valid) begin
                disp++;
                n_total++;
                if (sb.size() == 0) $display("FAIL stream: got %h, none expected", out_pc);
                else begin
                    e = sb.pop_front();
                    if (out_pc !== e) $display("FAIL stream: got %h exp %h", out_pc, e); else n_pass++;
                end
            end
            if (in_pc_valid && in_pc_ready) begin
                sb.push_back(nxt);
                nxt++;
            end
            cyc();
        end
        in_pc_valid = 0;
        bb_busy = 0;
        n_total++;
        if ({disp == 40, sb.size() == 0} !== 2'b11) $display("FAIL stream_count: dispatched=%0d left=%0d exp 40 0", disp, sb.size()); else n_pass++;
        run_bb(0, 60, adv_n, first_c, run_ok);
        finish_run();
    endtask

    task automatic test_reset_mid_run();
        sb.delete();
        out_pc_ready = 0;
        do_start(8'h50, 8);
        in_pc_valid = 1;
        in_pc = 8'h51;
        in_dir = 1;
        bb_busy = 1;
        cyc();
        in_pc = 8'h52;
        in_dir = 0;
        cyc();
        in_pc_valid = 0;
        bb_busy = 0;
        reset = 1;
        @(negedge clk);
        n_total++;
        if ({start_ready, in_pc_ready, out_pc_valid, out_pc, advance, done, match, char_index} !== '0)
            $display("FAIL mid_reset: got %h exp 0", {start_ready, in_pc_ready, out_pc_valid, out_pc, advance, done, match, char_index});
        else n_pass++;
        cyc();
        reset = 0;
        @(negedge clk);
        n_total++;
        if ({start_ready, in_pc_ready, out_pc_valid, advance, done, match, char_index} !== {1'b1, 21'd0})
            $display("FAIL mid_idle: got %h exp %h", {start_ready, in_pc_ready, out_pc_valid, advance, done, match, char_index}, {1'b1, 21'd0});
        else n_pass++;
        sb.delete();
        out_pc_ready = 1;
        do_start(8'h60, 8);
        run_bb(0, 60, adv_n, first_c, run_ok);
        n_total++;
        if ({first_c == 0, adv_n == 0, sb.size() == 0, match} !== 4'b1110)
            $display("FAIL mid_restart: first=%0d adv=%0d left=%0d match=%b exp 0 0 0 0", first_c, adv_n, sb.size(), match);
        else n_pass++;
        finish_run();
    endtask

    initial begin
        test_reset();
        test_single_char();
        test_advance(4, 3);
        test_advance(1, 0);
        test_accept();
        test_full_fifo();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
